// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, sequencer state encoding, op-class helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Operation codes as produced by the ALU decoder.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;

  // Sequencer states: waiting for work, iterating a shift, presenting a result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Shifts are the only multi-cycle operations.
  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops: ADD/SUB (wrapping), AND/OR/XOR; shift and illegal codes yield 0.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the output is captured.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the operation; carries/overflow fall off the top of the result width.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops via alu_comb, shifts iterated one bit per cycle.
// Latency: result valid 1 cycle after accept, or 1+shamt cycles for shifts with shamt>0.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, so issue interval >= 2.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_nxt;
  logic [4:0]       cnt;
  logic             sh_right;
  logic [WIDTH-1:0] comb_y;
  logic             accept;
  logic             op_shift;
  logic [4:0]       shamt;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .op (alucontrol),
    .a  (a),
    .b  (b),
    .y  (comb_y)
  );

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign op_shift  = is_shift(alucontrol);
  assign shamt     = b[4:0];
  assign sh_nxt    = sh_right ? (shreg >> 1) : (shreg << 1);

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a shift leaves SHIFT on the edge that performs its last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (op_shift && (shamt != 5'd0)) ? SHIFT : HOLD;
        end
      end
      SHIFT: begin
        if (cnt == 5'd1) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, step the shifter, load result/zero when done.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= 5'd0;
      sh_right <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_shift) begin
              shreg    <= a;
              cnt      <= shamt;
              sh_right <= (alucontrol == ALU_SRL);
              if (shamt == 5'd0) begin
                result <= a;
                zero   <= (a == '0);
              end
            end else begin
              result <= comb_y;
              zero   <= (comb_y == '0);
            end
          end
        end
        SHIFT: begin
          shreg <= sh_nxt;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= sh_nxt;
            zero   <= (sh_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes expected results, monitor pops on output transfers.
// Latency: checked per transaction against hand-computed cycle counts.
// Backpressure: out_ready driven always-1, randomly, or held low to exercise HOLD.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[13];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   or_mode = 0;
  logic rnd_bit = 1'b1;
  logic first_seen = 1'b0;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 2) != 0);
  end

  always_comb begin
    out_ready = 1'b1;
    if (or_mode == 1) out_ready = rnd_bit;
    else if (or_mode == 2) out_ready = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: latency on first valid cycle, stability while held, value on transfer.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got result %h with nothing outstanding", result);
      end else begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
        end else begin
          chk("hold_result", result, sbq[0].res);
        end
        if (out_ready) begin
          chk("result", result, sbq[0].res);
          chk("zero", {31'd0, zero}, {31'd0, sbq[0].z});
          void'(sbq.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    bit done = 0;
    alucontrol = v.op;
    a          = v.a;
    b          = v.b;
    in_valid   = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{v.exp, v.z, v.lat, cyc});
        done = 1;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    a          = $urandom;
    b          = $urandom;
    alucontrol = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) done = 1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{ALU_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1};
    vt[1]  = '{ALU_SUB, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1};
    vt[2]  = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};
    vt[3]  = '{ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1};
    vt[4]  = '{ALU_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1};
    vt[5]  = '{ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1};
    vt[6]  = '{ALU_ILL, 32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 1'b1, 1};
    vt[7]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
    vt[8]  = '{ALU_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
    vt[9]  = '{ALU_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5};
    vt[10] = '{ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1};
    vt[11] = '{ALU_SRL, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b1, 4};
    vt[12] = '{ALU_SLL, 32'h0000_0003, 32'h0000_0001, 32'h0000_0006, 1'b0, 2};

    reset      = 1'b1;
    in_valid   = 1'b0;
    alucontrol = 3'd0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with immediate consumption, then with random consumer stalls.
    or_mode = 0;
    foreach (vt[i]) issue(vt[i]);
    drain();
    or_mode = 1;
    foreach (vt[i]) issue(vt[i]);
    drain();

    // Consumer holds off for 10 cycles; a request arriving alongside consumption must wait.
    or_mode = 2;
    issue('{ALU_XOR, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0FF0_00FF, 1'b0, 1});
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    or_mode    = 0;
    in_valid   = 1'b1;
    alucontrol = ALU_ADD;
    a          = 32'd7;
    b          = 32'd8;
    @(negedge clk);
    chk("ready_on_consume", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    issue('{ALU_ADD, 32'd7, 32'd8, 32'h0000_000F, 1'b0, 1});
    drain();

    // Reset in the middle of a long shift discards it.
    issue('{ALU_SLL, 32'h0000_0001, 32'h0000_0014, 32'h0010_0000, 1'b0, 21});
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    chk("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(vt[0]);
    drain();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
